// File: rtl/mem8_reader.sv
// Burst reader: range-checks a request, then streams words from a
// combinational-read memory to a valid/ready consumer while summing them.
module mem8_reader #(
    parameter int ADDR_W   = 27,
    parameter int DATA_W   = 32,
    parameter int MEM_LAST = 35660,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam int SUM_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] LAST = SUM_W'(MEM_LAST);

    typedef enum logic [1:0] {IDLE, CHECK, READ, HOLD} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  addr_lat;
    logic [CNT_W-1:0]   remaining;
    logic [SUM_W-1:0]   last_addr;

    logic load, start_read, capture, xfer, advance, finish, range_fail;

    // Only consulted in CHECK, where remaining >= 1, so no underflow.
    assign last_addr = SUM_W'(addr_lat) + SUM_W'(remaining) - SUM_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        start_read = 1'b0;
        capture    = 1'b0;
        xfer       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        range_fail = 1'b0;
        mem_rd_en  = (state == READ);
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (remaining == '0) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (last_addr > LAST) begin
                    range_fail = 1'b1;
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    start_read = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (out_valid && out_ready) begin
                    xfer = 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = READ;
                    end
                end
            end
        endcase
    end

    // The count latched on start doubles as the remaining-word counter;
    // the address is staged separately so a rejected burst leaves mem_addr alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lat  <= '0;
            remaining <= '0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= finish;
            if (load) begin
                addr_lat  <= start_addr;
                remaining <= word_count;
                checksum  <= '0;
                err       <= 1'b0;
            end
            if (range_fail)
                err <= 1'b1;
            if (start_read)
                mem_addr <= addr_lat;
            if (capture) begin
                out_data  <= mem_data;
                out_valid <= 1'b1;
            end
            if (xfer) begin
                checksum  <= checksum + out_data;
                remaining <= remaining - CNT_W'(1);
                out_valid <= 1'b0;
            end
            if (advance)
                mem_addr <= mem_addr + ADDR_W'(1);
            if (busy && abort)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem8_reader.sv
// Bench for mem8_reader: queue-based burst model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem8_reader;

    localparam int ADDR_W   = 27;
    localparam int DATA_W   = 32;
    localparam int MEM_LAST = 35660;
    localparam int CNT_W    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  word_count;
    logic              abort;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] checksum;

    mem8_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAST(MEM_LAST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .word_count(word_count), .abort(abort), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_data(mem_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Memory contents: mem[i] = i + 1, returns zero when not enabled.
    assign mem_data = mem_rd_en ? (32'(mem_addr) + 32'd1) : 32'd0;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int rd_cycles = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] m_sum;
    logic        m_err;
    logic        m_active;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    // Model: each accepted start yields the list of words the burst must deliver.
    always @(negedge clk) begin
        longint a, c;
        if (!rst_n) begin
            exp_q.delete();
            m_sum    = '0;
            m_err    = 1'b0;
            m_active = 1'b0;
        end else begin
            check("checksum", checksum, m_sum);
            if (mem_rd_en) begin
                rd_cycles++;
                addr_log.push_back(32'(mem_addr));
                check("rd_in_hold", out_valid, 0);
                check("rd_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("rd_addr", mem_addr, exp_q[0] - 32'd1);
            end
            if (out_valid) begin
                check("valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready && !abort) begin
                        m_sum = m_sum + exp_q[0];
                        got_q.push_back(out_data);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                done_cnt++;
                check("done_expected", m_active, 1);
                if (m_active) begin
                    check("done_words_left", exp_q.size(), 0);
                    check("done_err", err, m_err);
                end
                m_active = 1'b0;
            end
            if (abort && busy) begin
                exp_q.delete();
                m_active = 1'b0;
            end
            if (start && !busy) begin
                a = longint'(start_addr);
                c = longint'(word_count);
                m_sum    = '0;
                m_active = 1'b1;
                m_err    = (c != 0) && (a + c - 1 > MEM_LAST);
                exp_q.delete();
                if (c != 0 && !m_err)
                    for (longint k = 0; k < c; k++) exp_q.push_back(32'(a + k + 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] c);
        start_addr = a;
        word_count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({"idle_timeout_", name}, n < budget, 1);
        tick();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check({"valid_timeout_", name}, n < budget, 1);
    endtask

    task automatic check_reset(input string name);
        check({name, "_mem_addr"}, mem_addr, 0);
        check({name, "_rd_en"}, mem_rd_en, 0);
        check({name, "_out_data"}, out_data, 0);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_err"}, err, 0);
        check({name, "_checksum"}, checksum, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0, r0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0;
        abort = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst0");
        rst_n = 1'b1;
        tick();

        // Basic burst and start-to-valid latency
        got_q.delete(); addr_log.delete(); d0 = done_cnt;
        start_addr = 27'd10; word_count = 16'd3; start = 1'b1;
        n = 0;
        do begin
            tick();
            start = 1'b0;
            n++;
        end while (!out_valid && n < 20);
        check("t1_latency", n, 3);
        wait_idle("t1", 50);
        check("t1_word0", qget(got_q, 0), 11);
        check("t1_word1", qget(got_q, 1), 12);
        check("t1_word2", qget(got_q, 2), 13);
        check("t1_addr0", qget(addr_log, 0), 10);
        check("t1_addr1", qget(addr_log, 1), 11);
        check("t1_addr2", qget(addr_log, 2), 12);
        check("t1_checksum", checksum, 36);
        check("t1_err", err, 0);
        check("t1_dones", done_cnt - d0, 1);
        check("t1_addr_idle", mem_addr, 12);

        // Backpressure on the second word; start pulses while busy are ignored
        d0 = done_cnt;
        do_start(27'd10, 16'd3);
        wait_valid("t2", 20);
        tick();
        out_ready = 1'b0;
        start_addr = 27'd100; word_count = 16'd7; start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_data", out_data, 12);
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_rd_en", mem_rd_en, 0);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        wait_idle("t2", 50);
        check("t2_checksum", checksum, 36);
        check("t2_dones", done_cnt - d0, 1);

        // Range limits and zero count
        r0 = rd_cycles; d0 = done_cnt;
        do_start(27'd35660, 16'd1);
        wait_idle("t3a", 50);
        check("t3a_err", err, 0);
        check("t3a_checksum", checksum, 35661);
        check("t3a_reads", rd_cycles - r0, 1);

        r0 = rd_cycles; d0 = done_cnt;
        do_start(27'd35660, 16'd2);
        wait_idle("t3b", 50);
        check("t3b_err", err, 1);
        check("t3b_reads", rd_cycles - r0, 0);
        check("t3b_dones", done_cnt - d0, 1);

        r0 = rd_cycles;
        start_addr = 27'd5; word_count = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t3c_check_done", done, 0);
        check("t3c_check_busy", busy, 1);
        tick();
        check("t3c_done", done, 1);
        check("t3c_busy", busy, 0);
        check("t3c_err", err, 0);
        tick();
        check("t3c_done_len", done, 0);
        check("t3c_reads", rd_cycles - r0, 0);

        r0 = rd_cycles; addr_log.delete();
        do_start(27'd35650, 16'd11);
        wait_idle("t3d", 100);
        check("t3d_err", err, 0);
        check("t3d_checksum", checksum, 392216);
        check("t3d_reads", rd_cycles - r0, 11);
        check("t3d_last_addr", qget(addr_log, 10), 35660);

        r0 = rd_cycles;
        do_start(27'h7FF_FFFF, 16'd2);
        wait_idle("t3e", 50);
        check("t3e_err", err, 1);
        check("t3e_reads", rd_cycles - r0, 0);
        repeat (3) tick();
        check("t3e_err_hold", err, 1);

        // Abort coinciding with the second transfer
        d0 = done_cnt;
        do_start(27'd10, 16'd3);
        check("t4_err_cleared", err, 0);
        wait_valid("t4", 20);
        tick();
        tick();
        check("t4_second_word", out_data, 12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_valid", out_valid, 0);
        check("t4_rd_en", mem_rd_en, 0);
        check("t4_checksum", checksum, 11);
        do_start(27'd10, 16'd3);
        check("t4_restart", busy, 1);
        check("t4_no_done", done_cnt - d0, 0);
        wait_idle("t4", 50);
        check("t4_checksum2", checksum, 36);
        check("t4_dones", done_cnt - d0, 1);

        // Asynchronous reset while holding a word
        out_ready = 1'b0;
        do_start(27'd10, 16'd3);
        wait_valid("t5", 20);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("t5_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        got_q.delete(); d0 = done_cnt;
        do_start(27'd10, 16'd3);
        wait_idle("t5", 50);
        check("t5_word0", qget(got_q, 0), 11);
        check("t5_word2", qget(got_q, 2), 13);
        check("t5_checksum", checksum, 36);
        check("t5_err", err, 0);
        check("t5_dones", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem8_reader.md
MEM8_READER -- requirements
Module: mem8_reader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 27, memory word-address width.
- DATA_W, 32, memory word width.
- MEM_LAST, 35660, highest valid word address of the attached memory.
- CNT_W, 16, word-count width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state changes on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request a burst read; sampled only in IDLE.
- start_addr, in, ADDR_W, first word address of the burst.
- word_count, in, CNT_W, number of words to read.
- abort, in, 1, cancel the burst in progress.
- mem_addr, out, ADDR_W, address to the memory read port.
- mem_rd_en, out, 1, read enable to the memory; the memory returns data combinationally in the same cycle.
- mem_data, in, DATA_W, memory read data; zero when mem_rd_en is low.
- out_data, out, DATA_W, captured word.
- out_valid, out, 1, out_data is valid.
- out_ready, in, 1, downstream accepts out_data.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse at burst completion.
- err, out, 1, range error flag; holds until the next accepted start.
- checksum, out, DATA_W, modulo-2^32 sum of all words accepted by downstream in the current or most recent burst.

Function
REQ-003 The FSM SHALL have four states: IDLE, CHECK, READ and HOLD.
REQ-004 In IDLE with start=1, the block SHALL latch start_addr and word_count, clear checksum and err, and go to CHECK.
REQ-005 In CHECK, if word_count=0 the block SHALL pulse done and return to IDLE with no read.
REQ-006 In CHECK, if start_addr+word_count-1 > MEM_LAST, the block SHALL set err=1, pulse done and return to IDLE with no read. The sum SHALL be computed at ADDR_W+1 bits or wider so that it cannot overflow.
REQ-007 Otherwise, CHECK SHALL load mem_addr=start_addr and a remaining-word counter=word_count, then go to READ.
REQ-008 mem_rd_en SHALL be 1 only while in READ, and for exactly one cycle per word.
REQ-009 In READ, the block SHALL register mem_data into out_data, set out_valid=1 and go to HOLD.
REQ-010 In HOLD, out_data and out_valid SHALL remain stable until out_valid and out_ready are both 1 at a clock edge (the transfer).
REQ-011 On a transfer, the block SHALL add out_data to checksum, decrement the remaining-word counter and clear out_valid. If the counter reaches 0, it SHALL pulse done and go to IDLE. Otherwise it SHALL increment mem_addr by 1 and go to READ.
REQ-012 Throughput SHALL be at most one word per two cycles. Latency from start to the first out_valid SHALL be 3 cycles: IDLE, then CHECK, then READ.
REQ-013 start SHALL be ignored in every state except IDLE.
REQ-014 abort=1 in any non-IDLE state SHALL, at the next edge, go to IDLE and clear out_valid and mem_rd_en. No done pulse SHALL follow, and checksum SHALL keep the sum of words already transferred.
REQ-015 abort SHALL take priority over a simultaneous transfer. A word whose transfer coincides with abort SHALL NOT be counted.
REQ-016 mem_addr SHALL hold its last value while idle.
REQ-017 The largest permitted burst SHALL read address MEM_LAST last without error.

Reset
REQ-018 While rst_n=0, the following SHALL be forced immediately: state=IDLE, mem_addr=0, mem_rd_en=0, out_data=0, out_valid=0, busy=0, done=0, err=0, checksum=0.
REQ-019 Reset asserted mid-burst SHALL discard the burst. The first start after rst_n rises SHALL behave as in REQ-004.

Verification
REQ-020 Basic burst: memory preloaded with mem[i]=i+1; start_addr=10, word_count=3, out_ready held 1. Required response: mem_addr steps 10, 11, 12; out_data sequence 11, 12, 13; done pulses once; checksum=36; err=0.
REQ-021 Backpressure: the REQ-020 burst with out_ready=0 for 5 cycles on the second word. Required response: out_data=12 held stable with out_valid=1 throughout; mem_rd_en stays 0 while in HOLD; final checksum=36.
REQ-022 Range and zero count:
- start_addr=35660, word_count=1: one read, err=0.
- start_addr=35660, word_count=2: err=1, done pulse, mem_rd_en never asserted.
- word_count=0: done pulse in the cycle after CHECK, no read.
REQ-023 Abort: the REQ-020 burst with abort=1 on the cycle of the second transfer. Required response: return to IDLE, no done pulse, checksum=11, start accepted on the following cycle.
REQ-024 Async reset: rst_n pulled low mid-HOLD between clock edges. Required response: all outputs at reset values before the next clk edge; a new burst then runs as in REQ-020.
